// File: rtl/req_queue4.sv
// req_queue4: four per-client request FIFOs that feed a rotating-priority arbiter.
// A non-empty FIFO raises its req line. The arbiter's ack pops the head word onto a
// shared registered output port, together with the ID of the winning client.
module req_queue4 #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid0,
  input  logic          in_valid1,
  input  logic          in_valid2,
  input  logic          in_valid3,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  input  logic [DW-1:0] in_data3,
  output logic          in_ready0,
  output logic          in_ready1,
  output logic          in_ready2,
  output logic          in_ready3,
  output logic          req0,
  output logic          req1,
  output logic          req2,
  output logic          req3,
  input  logic          ack0,
  input  logic          ack1,
  input  logic          ack2,
  input  logic          ack3,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_id,
  output logic          err_multi_ack,
  output logic          err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [AW:0]   count  [4];

  logic [DW-1:0] data_v [4];
  logic [3:0]    valid_v, ack_v, ready_v, req_v, push, pop, hit;
  logic [1:0]    pop_id;
  logic          pop_any;

  assign valid_v   = {in_valid3, in_valid2, in_valid1, in_valid0};
  assign ack_v     = {ack3, ack2, ack1, ack0};
  assign data_v[0] = in_data0;
  assign data_v[1] = in_data1;
  assign data_v[2] = in_data2;
  assign data_v[3] = in_data3;

  // in_ready and req depend only on the registered count. Nothing bypasses
  // from ack, so a full FIFO refuses a push even in a cycle when it pops.
  for (genvar g = 0; g < 4; g++) begin : g_flags
    assign ready_v[g] = (count[g] != CNT_FULL);
    assign req_v[g]   = (count[g] != '0);
    assign push[g]    = valid_v[g] & ready_v[g];
  end

  assign {in_ready3, in_ready2, in_ready1, in_ready0} = ready_v;
  assign {req3, req2, req1, req0} = req_v;

  // Pick the lowest-index ack that targets a non-empty queue; at most one pop per cycle.
  always_comb begin
    hit     = ack_v & req_v;
    pop_any = |hit;
    pop_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) pop_id = 2'(i);
    end
    pop = pop_any ? (4'b0001 << pop_id) : 4'b0000;
  end

  // Storage write. Contents are not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= data_v[i];
    end
  end

  // Pointer and occupancy bookkeeping for each FIFO. A push and a pop in the same cycle leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end

  // Registered output port and error pulses. Data and ID hold their values when no word is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= '0;
      err_multi_ack <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      out_valid     <= pop_any;
      err_multi_ack <= ((ack_v & (ack_v - 4'd1)) != 4'd0);
      err_spurious  <= |(ack_v & ~req_v);
      if (pop_any) begin
        out_data <= mem[pop_id][rd_ptr[pop_id]];
        out_id   <= pop_id;
      end
    end
  end

endmodule

// File: tb/tb_req_queue4.sv
// Directed testbench for req_queue4. Inputs change 1 time unit after each rising
// edge, and outputs are checked in that same window, away from the edge.
module tb_req_queue4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid0, in_valid1, in_valid2, in_valid3;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic       in_ready0, in_ready1, in_ready2, in_ready3;
  logic       req0, req1, req2, req3;
  logic       ack0, ack1, ack2, ack3;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       err_multi_ack, err_spurious;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  req_queue4 #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid0(in_valid0), .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready0(in_ready0), .in_ready1(in_ready1), .in_ready2(in_ready2), .in_ready3(in_ready3),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .err_multi_ack(err_multi_ack), .err_spurious(err_spurious)
  );

  wire [3:0] req_v   = {req3, req2, req1, req0};
  wire [3:0] ready_v = {in_ready3, in_ready2, in_ready1, in_ready0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {in_valid0, in_valid1, in_valid2, in_valid3} = 4'b0;
    {ack0, ack1, ack2, ack3} = 4'b0;
    in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
  endtask

  initial begin
    // 1. Hold reset for two cycles, then check the idle state.
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", ready_v, 4'hF);
    chk("rst_req", req_v, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_multi", err_multi_ack, 1'b0);
    chk("rst_err_spur", err_spurious, 1'b0);
    chk("rst_out_data", out_data, 8'h00);

    // 2. Single transfer on client 2.
    in_valid2 = 1'b1; in_data2 = 8'hA5;
    tick();
    in_valid2 = 1'b0;
    chk("t2_req", req_v, 4'b0100);
    ack2 = 1'b1;
    chk("t2_no_out_yet", out_valid, 1'b0);
    tick();
    ack2 = 1'b0;
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_data", out_data, 8'hA5);
    chk("t2_out_id", out_id, 2'd2);
    chk("t2_req_after", req_v, 4'h0);
    tick();
    chk("t2_valid_pulse", out_valid, 1'b0);
    chk("t2_data_hold", out_data, 8'hA5);

    // 3. Fill client 0, wrap its pointers, then drain in order.
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; in_data0 = 8'h10 + 8'(i);
      tick();
    end
    in_valid0 = 1'b0;
    chk("t3_full_ready", in_ready0, 1'b0);
    chk("t3_full_req", req0, 1'b1);
    ack0 = 1'b1;
    tick();
    chk("t3_pop0", out_data, 8'h10);
    tick();
    chk("t3_pop1", out_data, 8'h11);
    ack0 = 1'b0;
    chk("t3_ready_half", in_ready0, 1'b1);
    in_valid0 = 1'b1; in_data0 = 8'h14;
    tick();
    in_data0 = 8'h15;
    tick();
    in_valid0 = 1'b0;
    chk("t3_full_again", in_ready0, 1'b0);
    ack0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_drain_data", out_data, 8'h12 + 8'(i));
      chk("t3_drain_valid", out_valid, 1'b1);
    end
    ack0 = 1'b0;
    chk("t3_req_drop", req0, 1'b0);
    tick();

    // 4. Push and pop on client 1 in the same cycle.
    in_valid1 = 1'b1; in_data1 = 8'h31;
    tick();
    in_data1 = 8'h32;
    tick();
    in_data1 = 8'h77; ack1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("t4_head_out", out_data, 8'h31);
    chk("t4_head_id", out_id, 2'd1);
    chk("t4_req_kept", req1, 1'b1);
    tick();
    chk("t4_older", out_data, 8'h32);
    chk("t4_req_one_left", req1, 1'b1);
    tick();
    ack1 = 1'b0;
    chk("t4_new", out_data, 8'h77);
    chk("t4_req_empty", req1, 1'b0);
    tick();

    // 5a. Two acks at once with both queues non-empty.
    in_valid0 = 1'b1; in_data0 = 8'hA0;
    in_valid3 = 1'b1; in_data3 = 8'hD0;
    tick();
    in_valid0 = 1'b0;
    in_data3 = 8'hD1;
    tick();
    in_valid3 = 1'b0;
    ack0 = 1'b1; ack3 = 1'b1;
    tick();
    ack0 = 1'b0; ack3 = 1'b0;
    chk("t5a_err_multi", err_multi_ack, 1'b1);
    chk("t5a_err_spur", err_spurious, 1'b0);
    chk("t5a_out_id", out_id, 2'd0);
    chk("t5a_out_data", out_data, 8'hA0);
    chk("t5a_req", req_v, 4'b1000);
    tick();
    chk("t5a_multi_pulse", err_multi_ack, 1'b0);
    chk("t5a_idle_valid", out_valid, 1'b0);
    ack3 = 1'b1;
    tick();
    chk("t5a_q3_first", out_data, 8'hD0);
    tick();
    ack3 = 1'b0;
    chk("t5a_q3_second", out_data, 8'hD1);
    chk("t5a_q3_empty", req3, 1'b0);

    // 5b. Ack on an empty queue, first alone and then alongside a valid pop.
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("t5b_err_spur", err_spurious, 1'b1);
    chk("t5b_out_valid", out_valid, 1'b0);
    chk("t5b_no_multi", err_multi_ack, 1'b0);
    chk("t5b_data_hold", out_data, 8'hD1);
    tick();
    chk("t5b_spur_pulse", err_spurious, 1'b0);
    in_valid2 = 1'b1; in_data2 = 8'hB0;
    tick();
    in_valid2 = 1'b0;
    ack1 = 1'b1; ack2 = 1'b1;
    tick();
    ack1 = 1'b0; ack2 = 1'b0;
    chk("t5b_mix_spur", err_spurious, 1'b1);
    chk("t5b_mix_multi", err_multi_ack, 1'b1);
    chk("t5b_mix_valid", out_valid, 1'b1);
    chk("t5b_mix_id", out_id, 2'd2);
    chk("t5b_mix_data", out_data, 8'hB0);
    tick();

    // 6. Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      {in_valid0, in_valid1, in_valid2, in_valid3} = 4'hF;
      in_data0 = 8'h40 + 8'(i); in_data1 = 8'h50 + 8'(i);
      in_data2 = 8'h60 + 8'(i); in_data3 = 8'h70 + 8'(i);
      tick();
    end
    clear_inputs();
    chk("t6_loaded", req_v, 4'hF);
    rst = 1'b1; ack2 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hEE;
    tick();
    rst = 1'b0;
    clear_inputs();
    chk("t6_req", req_v, 4'h0);
    chk("t6_ready", ready_v, 4'hF);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_out_data", out_data, 8'h00);
    in_valid0 = 1'b1; in_data0 = 8'h5A;
    tick();
    in_valid0 = 1'b0;
    chk("t6_new_req", req_v, 4'b0001);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    chk("t6_new_data", out_data, 8'h5A);
    chk("t6_new_id", out_id, 2'd0);
    chk("t6_new_valid", out_valid, 1'b1);
    chk("t6_empty", req_v, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
